// File: rtl/sub_result_pkg.sv
// Shared types for the subtractor result stage.
// Holds the FSM state encoding and the statistics counter width.
// The per-entry packed struct {mag, neg, zero, res} depends on N, so each
// module that stores entries declares it locally from the same field order.
package sub_result_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/sub_result_fmt.sv
// Purpose: canonicalise a sign-magnitude subtractor result into a two's-complement value plus flags.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; it is driven every cycle and the caller decides when to capture.
// Ports: mag_raw/neg_raw (raw magnitude and sign) -> mag, neg, zero, res (N+1-bit signed).
module sub_result_fmt #(
  parameter int N = 4
) (
  input  logic [N-1:0] mag_raw,
  input  logic         neg_raw,
  output logic [N-1:0] mag,
  output logic         neg,
  output logic         zero,
  output logic [N:0]   res
);

  logic [N:0] mag_ext;

  assign mag_ext = {1'b0, mag_raw};
  assign mag     = mag_raw;
  assign zero    = (mag_raw == '0);
  // A zero magnitude is never reported negative, so -0 collapses to +0.
  assign neg     = neg_raw && !zero;
  // Magnitude is at most 2^N-1, so negating at N+1 bits cannot overflow.
  assign res     = neg ? (~mag_ext + 1'b1) : mag_ext;

endmodule

// File: rtl/sub_result_stage.sv
// Purpose: registered output stage after the sign-magnitude subtractor; canonicalises and buffers results.
// Latency: 1 cycle from input transfer to outValid; 1 result/cycle sustained.
// Backpressure: 2-entry skid buffer (OUT + SKID); inReady is registered, no comb path from outReady.
// Ports: clk, rst_n (async active-low); inValid/inReady/magIn/negIn upstream;
//        outValid/outReady/resOut/magOut/negOut/zeroOut downstream.
// Optional: define SUB_RESULT_STATS_EN to add saturating txCount/negCount outputs.
module sub_result_stage
  import sub_result_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inValid,
  output logic               inReady,
  input  logic [N-1:0]       magIn,
  input  logic               negIn,
  output logic               outValid,
  input  logic               outReady,
  output logic [N:0]         resOut,
  output logic [N-1:0]       magOut,
  output logic               negOut,
  output logic               zeroOut
`ifdef SUB_RESULT_STATS_EN
  ,
  output logic [STATS_W-1:0] txCount,
  output logic [STATS_W-1:0] negCount
`endif
);

  typedef struct packed {
    logic [N-1:0] mag;
    logic         neg;
    logic         zero;
    logic [N:0]   res;
  } entry_t;

  stage_state_t state, state_nxt;
  entry_t       fmt_ent, out_q, skid_q;
  logic [N-1:0] fmt_mag;
  logic         fmt_neg, fmt_zero;
  logic [N:0]   fmt_res;
  logic         in_xfer, out_xfer;
  logic         load_out_in, load_out_skid, load_skid;

  sub_result_fmt #(.N(N)) u_fmt (
    .mag_raw (magIn),
    .neg_raw (negIn),
    .mag     (fmt_mag),
    .neg     (fmt_neg),
    .zero    (fmt_zero),
    .res     (fmt_res)
  );

  assign fmt_ent  = '{mag: fmt_mag, neg: fmt_neg, zero: fmt_zero, res: fmt_res};
  assign in_xfer  = inValid && inReady;
  assign out_xfer = outValid && outReady;

  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_out_in = 1'b1;
          state_nxt   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_out_in = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end
      end
      TWO: begin
        // inReady is low here, so only the drain side can move.
        if (out_xfer) begin
          load_out_skid = 1'b1;
          state_nxt     = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // inReady/outValid are decoded from the next state so they are true registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nxt;
      inReady  <= (state_nxt != TWO);
      outValid <= (state_nxt != EMPTY);
      if (load_out_in) begin
        out_q <= fmt_ent;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= fmt_ent;
      end
    end
  end

  assign resOut  = out_q.res;
  assign magOut  = out_q.mag;
  assign negOut  = out_q.neg;
  assign zeroOut = out_q.zero;

`ifdef SUB_RESULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txCount  <= '0;
      negCount <= '0;
    end else if (out_xfer) begin
      if (txCount != '1) begin
        txCount <= txCount + 1'b1;
      end
      if (out_q.neg && (negCount != '1)) begin
        negCount <= negCount + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
module tb_sub_result_stage;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid;
  logic         inReady;
  logic [N-1:0] magIn;
  logic         negIn;
  logic         outValid;
  logic         outReady;
  logic [N:0]   resOut;
  logic [N-1:0] magOut;
  logic         negOut;
  logic         zeroOut;
`ifdef SUB_RESULT_STATS_EN
  logic [15:0]  txCount;
  logic [15:0]  negCount;
`endif

  sub_result_stage #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .magIn    (magIn),
    .negIn    (negIn),
    .outValid (outValid),
    .outReady (outReady),
    .resOut   (resOut),
    .magOut   (magOut),
    .negOut   (negOut),
    .zeroOut  (zeroOut)
`ifdef SUB_RESULT_STATS_EN
    ,
    .txCount  (txCount),
    .negCount (negCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] mag;
    logic         neg;
    logic         zero;
    logic [N:0]   res;
  } exp_t;

  int   n_total = 0;
  int   n_bad   = 0;
  int   n_out   = 0;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed arithmetic on int, truncated to N+1 bits.
  function automatic exp_t model(input logic [N-1:0] m, input logic n);
    exp_t e;
    int   v;
    e.mag  = m;
    e.zero = (m == 0);
    e.neg  = n && (m != 0);
    v      = e.neg ? -int'(m) : int'(m);
    e.res  = v[N:0];
    return e;
  endfunction

  // Monitor: scoreboard push on input transfer, pop/compare on output transfer,
  // plus output stability while stalled.
  logic             stalled = 1'b0;
  logic [2*N+2:0]   prev_out;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("hold_stable", {magOut, negOut, zeroOut, resOut}, prev_out);
      if (outValid && outReady) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_res", resOut, e.res);
          chk("out_mag", magOut, e.mag);
          chk("out_neg", negOut, e.neg);
          chk("out_zero", zeroOut, e.zero);
        end
        n_out++;
      end
      if (inValid && inReady) sb_q.push_back(model(magIn, negIn));
      stalled  = outValid && !outReady;
      prev_out = {magOut, negOut, zeroOut, resOut};
    end
  end

  task automatic send(input logic [N-1:0] m, input logic n);
    bit ok;
    ok      = 1'b0;
    inValid = 1'b1;
    magIn   = m;
    negIn   = n;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (inReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] m;
    logic         n;
    logic [N:0]   r;
    logic         eneg;
    logic         ezero;
  } vec_t;

  vec_t vecs[4] = '{
    '{m: 4'd5,  n: 1'b1, r: 5'b11011, eneg: 1'b1, ezero: 1'b0},
    '{m: 4'd0,  n: 1'b1, r: 5'b00000, eneg: 1'b0, ezero: 1'b1},
    '{m: 4'd15, n: 1'b1, r: 5'b10001, eneg: 1'b1, ezero: 1'b0},
    '{m: 4'd15, n: 1'b0, r: 5'b01111, eneg: 1'b0, ezero: 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    magIn    = '0;
    negIn    = 1'b0;
    outReady = 1'b1;
    #12;
    chk("rst_outValid", outValid, 0);
    chk("rst_inReady", inReady, 0);
    chk("rst_outputs", {resOut, magOut, negOut, zeroOut}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_inReady", inReady, 1);
    chk("post_rst_outValid", outValid, 0);

    // Directed canonicalisation vectors.
    foreach (vecs[i]) begin
      send(vecs[i].m, vecs[i].n);
      chk("dir_valid", outValid, 1);
      chk("dir_res", resOut, vecs[i].r);
      chk("dir_mag", magOut, vecs[i].m);
      chk("dir_neg", negOut, vecs[i].eneg);
      chk("dir_zero", zeroOut, vecs[i].ezero);
      idle(1);
    end

    // Backpressure: A, B fill both entries, C must wait.
    outReady = 1'b0;
    send(4'd3, 1'b0);
    send(4'd7, 1'b0);
    chk("bp_inReady_after_B", inReady, 0);
    chk("bp_outA_res", resOut, 5'd3);
    inValid = 1'b1;
    magIn   = 4'd9;
    negIn   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_inReady", inReady, 0);
      chk("bp_hold_outValid", outValid, 1);
    end
    @(posedge clk);
    #1 outReady = 1'b1;
    @(negedge clk);
    chk("bp_drainA_valid", outValid, 1);
    chk("bp_drainA_res", resOut, 5'd3);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_drainB_valid", outValid, 1);
    chk("bp_drainB_res", resOut, 5'd7);
    chk("bp_C_accept", inReady, 1);
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    chk("bp_drainC_valid", outValid, 1);
    chk("bp_drainC_res", resOut, 5'd9);
    @(posedge clk);
    #1;
    chk("bp_empty_valid", outValid, 0);
    chk("bp_empty_inReady", inReady, 1);

    // Reset with both entries full: nothing stale may appear afterwards.
    outReady = 1'b0;
    send(4'd2, 1'b1);
    send(4'd4, 1'b1);
    chk("mid_full_inReady", inReady, 0);
    rst_n = 1'b0;
    sb_q.delete();
    #2;
    chk("mid_rst_outValid", outValid, 0);
    chk("mid_rst_inReady", inReady, 0);
    chk("mid_rst_outputs", {resOut, magOut, negOut, zeroOut}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_post_inReady", inReady, 1);
    chk("mid_post_outValid", outValid, 0);
    idle(3);
    chk("mid_no_stale", outValid, 0);

    // Streaming 16 back-to-back results with outReady held high.
    base = n_out;
    inValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      magIn = 4'(i);
      negIn = (i % 2 == 0);
      @(negedge clk);
      chk("stream_inReady", inReady, 1);
      if (i > 0) chk("stream_outValid", outValid, 1);
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", outValid, 1);
    idle(2);
    chk("stream_count", n_out - base, 16);
    chk("stream_empty", outValid, 0);
`ifdef SUB_RESULT_STATS_EN
    chk("stats_tx", txCount, 16);
    chk("stats_neg", negCount, 7);
`endif
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
